// File: rtl/alu_stage.sv
// ---------------------------------------------------------------------------
// alu_stage
//    Execute (ALU) pipeline stage of the 16-bit CPU, placed between
//    decode/register-read and writeback. A 16-bit result is computed from
//    two register operands or a zero-extended 9-bit immediate, selected by a
//    4-bit opcode. The result, carry/borrow flag, destination register
//    address and write enable are registered, giving one cycle of latency.
//
// Ports
//    clk                 in   1   rising-edge clock
//    reset               in   1   asynchronous, active-low reset
//    enable              in   1   stage enable; 0 holds every output register
//    regA                in   16  operand A (register read data)
//    regB                in   16  operand B (register read data)
//    cop                 in   4   ALU opcode
//    destReg_adr         in   3   destination register address, forwarded
//    we                  in   1   register-file write enable, forwarded
//    regA_adr            in   3   immediate bits [8:6]
//    regB_adr            in   3   immediate bits [5:3]
//    inst_freeBits       in   3   immediate bits [2:0]
//    alu_result          out  16  registered ALU result
//    OVF                 out  1   registered carry/borrow flag
//    destReg_adr_output  out  3   registered destReg_adr
//    we_output           out  1   registered write enable
//
// Configuration
//    ALU_SHIFT_EN  when defined, opcodes 1000/1001/1010 perform SHL/SHR/SRA
//                  by regB[3:0]; when undefined they behave as reserved
//                  opcodes (result 0, flag 0, writeback suppressed).
// ---------------------------------------------------------------------------
module alu_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] regA,
   input  logic [15:0] regB,
   input  logic [3:0]  cop,
   input  logic [2:0]  destReg_adr,
   input  logic        we,
   input  logic [2:0]  regA_adr,
   input  logic [2:0]  regB_adr,
   input  logic [2:0]  inst_freeBits,
   output logic [15:0] alu_result,
   output logic        OVF,
   output logic [2:0]  destReg_adr_output,
   output logic        we_output
);

   typedef enum logic [3:0] {
      OP_PASS = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_MOV  = 4'b0011,
      OP_AND  = 4'b0100,
      OP_OR   = 4'b0101,
      OP_XOR  = 4'b0110,
      OP_NOT  = 4'b0111,
      OP_SHL  = 4'b1000,
      OP_SHR  = 4'b1001,
      OP_SRA  = 4'b1010
   } alu_op_e;

   alu_op_e     op;
   logic [15:0] imm;
   logic [16:0] sum;
   logic [16:0] diff;
   logic [15:0] alu_val;
   logic        alu_ovf;
   logic        alu_wr;

   logic [15:0] result_d, result_q;
   logic        ovf_d, ovf_q;
   logic [2:0]  dest_d, dest_q;
   logic        we_d, we_q;

   assign op   = alu_op_e'(cop);
   assign imm  = {7'b0, regA_adr, regB_adr, inst_freeBits};
   // Widened by one bit so the top bit is the carry out / borrow.
   assign sum  = {1'b0, regA} + {1'b0, regB};
   assign diff = {1'b0, regA} - {1'b0, regB};

   // Combinational ALU. Any opcode not listed (reserved, or the shift
   // opcodes in a build without shifts) yields zero and kills writeback.
   always_comb begin
      alu_val = 16'h0000;
      alu_ovf = 1'b0;
      alu_wr  = we;
      case (op)
         OP_PASS: alu_val = regA;
         OP_ADD: begin
            alu_val = sum[15:0];
            alu_ovf = sum[16];
         end
         OP_SUB: begin
            alu_val = diff[15:0];
            alu_ovf = diff[16];
         end
         OP_MOV:  alu_val = imm;
         OP_AND:  alu_val = regA & regB;
         OP_OR:   alu_val = regA | regB;
         OP_XOR:  alu_val = regA ^ regB;
         OP_NOT:  alu_val = ~regA;
`ifdef ALU_SHIFT_EN
         OP_SHL:  alu_val = regA << regB[3:0];
         OP_SHR:  alu_val = regA >> regB[3:0];
         OP_SRA:  alu_val = $unsigned($signed(regA) >>> regB[3:0]);
`endif
         default: begin
            alu_val = 16'h0000;
            alu_ovf = 1'b0;
            alu_wr  = 1'b0;
         end
      endcase
   end

   // Next-state for the output registers: capture when enabled, hold
   // otherwise.
   always_comb begin
      result_d = result_q;
      ovf_d    = ovf_q;
      dest_d   = dest_q;
      we_d     = we_q;
      if (enable) begin
         result_d = alu_val;
         ovf_d    = alu_ovf;
         dest_d   = destReg_adr;
         we_d     = alu_wr;
      end
   end

   // Output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= 16'h0000;
         ovf_q    <= 1'b0;
         dest_q   <= 3'b000;
         we_q     <= 1'b0;
      end else begin
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dest_q   <= dest_d;
         we_q     <= we_d;
      end
   end

   assign alu_result         = result_q;
   assign OVF                = ovf_q;
   assign destReg_adr_output = dest_q;
   assign we_output          = we_q;

endmodule

// File: tb/tb_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_stage
//    Directed-vector bench for alu_stage. A behavioural model computes the
//    expected registered outputs from the opcode rules using plain wide
//    arithmetic; a compare process checks the DUT against it on every
//    falling edge, and hand-computed literals pin specific results.
// ---------------------------------------------------------------------------
module tb_alu_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] regA;
   logic [15:0] regB;
   logic [3:0]  cop;
   logic [2:0]  destReg_adr;
   logic        we;
   logic [2:0]  regA_adr;
   logic [2:0]  regB_adr;
   logic [2:0]  inst_freeBits;
   logic [15:0] alu_result;
   logic        OVF;
   logic [2:0]  destReg_adr_output;
   logic        we_output;

   int checks = 0;
   int errors = 0;

   logic [15:0] mResult = 16'h0000;
   logic        mOvf    = 1'b0;
   logic [2:0]  mDest   = 3'b000;
   logic        mWe     = 1'b0;

   alu_stage dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .regA               (regA),
      .regB               (regB),
      .cop                (cop),
      .destReg_adr        (destReg_adr),
      .we                 (we),
      .regA_adr           (regA_adr),
      .regB_adr           (regB_adr),
      .inst_freeBits      (inst_freeBits),
      .alu_result         (alu_result),
      .OVF                (OVF),
      .destReg_adr_output (destReg_adr_output),
      .we_output          (we_output)
   );

   always #5 clk = ~clk;

   // Expected {writeEnable, flag, result} for one operation, derived from
   // integer arithmetic on the operand values.
   function automatic logic [17:0] modelAlu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic weIn,
                                            input logic [8:0] immVal);
      int unsigned ua;
      int unsigned ub;
      int unsigned r;
      int          sa;
      logic        f;
      logic        w;
      ua = a;
      ub = b;
      sa = int'($signed(a));
      r  = 0;
      f  = 1'b0;
      w  = weIn;
      case (op)
         4'd0: r = ua;
         4'd1: begin r = (ua + ub) % 65536; f = (ua + ub) > 65535; end
         4'd2: begin r = (ua + 65536 - ub) % 65536; f = ua < ub; end
         4'd3: r = immVal;
         4'd4: r = ua & ub;
         4'd5: r = ua | ub;
         4'd6: r = ua ^ ub;
         4'd7: r = 65535 - ua;
`ifdef ALU_SHIFT_EN
         4'd8: r = (ua * (1 << (ub % 16))) % 65536;
         4'd9: r = ua / (1 << (ub % 16));
         4'd10: r = unsigned'(sa >>> (ub % 16)) % 65536;
`endif
         default: begin r = 0; w = 1'b0; end
      endcase
      return {w, f, r[15:0]};
   endfunction

   // Model of the registered outputs.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mResult <= 16'h0000;
         mOvf    <= 1'b0;
         mDest   <= 3'b000;
         mWe     <= 1'b0;
      end else if (enable) begin
         {mWe, mOvf, mResult} <= modelAlu(cop, regA, regB, we,
                                          {regA_adr, regB_adr, inst_freeBits});
         mDest <= destReg_adr;
      end
   end

   // Compare DUT against model on every falling edge.
   always @(negedge clk) begin
      checks++;
      if (alu_result !== mResult || OVF !== mOvf ||
          destReg_adr_output !== mDest || we_output !== mWe) begin
         errors++;
         $display("[TB] FAIL model t=%0t: got res=%h ovf=%b dest=%0d we=%b want res=%h ovf=%b dest=%0d we=%b",
                  $time, alu_result, OVF, destReg_adr_output, we_output,
                  mResult, mOvf, mDest, mWe);
      end
   end

   task automatic applyStimulus(input logic en, input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic weIn,
                                input logic [2:0] dest, input logic [8:0] immVal);
      @(negedge clk);
      enable        = en;
      cop           = op;
      regA          = a;
      regB          = b;
      we            = weIn;
      destReg_adr   = dest;
      regA_adr      = immVal[8:6];
      regB_adr      = immVal[5:3];
      inst_freeBits = immVal[2:0];
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] expRes, input logic expOvf,
                              input logic expWe, input logic [2:0] expDest);
      checks++;
      if (alu_result !== expRes || OVF !== expOvf ||
          we_output !== expWe || destReg_adr_output !== expDest) begin
         errors++;
         $display("[TB] FAIL %s: got res=%h ovf=%b we=%b dest=%0d want res=%h ovf=%b we=%b dest=%0d",
                  name, alu_result, OVF, we_output, destReg_adr_output,
                  expRes, expOvf, expWe, expDest);
      end
   endtask

   logic [15:0] sweepExp [7];

   initial begin
      sweepExp = '{16'h0001, 16'h0002, 16'h0000, 16'h0049, 16'h0001, 16'h0001, 16'h0000};
      reset         = 1'b0;
      enable        = 1'b1;
      regA          = 16'h0000;
      regB          = 16'h0000;
      cop           = 4'b0000;
      destReg_adr   = 3'b000;
      we            = 1'b0;
      regA_adr      = 3'b000;
      regB_adr      = 3'b000;
      inst_freeBits = 3'b000;
      #2;
      checkOutput("resetState", 16'h0000, 1'b0, 1'b0, 3'b000);

      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("afterRelease", 16'h0000, 1'b0, 1'b0, 3'b000);

      applyStimulus(1'b1, 4'b0001, 16'h0001, 16'h0001, 1'b1, 3'b001, 9'h000);
      checkOutput("add1p1", 16'h0002, 1'b0, 1'b1, 3'b001);
      applyStimulus(1'b1, 4'b0001, 16'h0001, 16'hFFFF, 1'b1, 3'b010, 9'h000);
      checkOutput("addCarry", 16'h0000, 1'b1, 1'b1, 3'b010);
      applyStimulus(1'b1, 4'b0001, 16'hFFFF, 16'hFFFF, 1'b1, 3'b011, 9'h000);
      checkOutput("addMax", 16'hFFFE, 1'b1, 1'b1, 3'b011);
      applyStimulus(1'b1, 4'b0010, 16'h0001, 16'h0001, 1'b1, 3'b100, 9'h000);
      checkOutput("sub1m1", 16'h0000, 1'b0, 1'b1, 3'b100);
      applyStimulus(1'b1, 4'b0010, 16'h0001, 16'h0002, 1'b1, 3'b101, 9'h000);
      checkOutput("subBorrow", 16'hFFFF, 1'b1, 1'b1, 3'b101);
      applyStimulus(1'b1, 4'b0011, 16'h1234, 16'h5678, 1'b1, 3'b110, 9'b001_001_001);
      checkOutput("movImm", 16'h0049, 1'b0, 1'b1, 3'b110);
      applyStimulus(1'b1, 4'b0011, 16'h0000, 16'h0000, 1'b0, 3'b111, 9'h1FF);
      checkOutput("movImmMax", 16'h01FF, 1'b0, 1'b0, 3'b111);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, i[3:0], 16'h0001, 16'h0001, 1'b1, 3'b010, 9'b001_001_001);
         checkOutput($sformatf("sweepCop%0d", i), sweepExp[i], (i == 1) ? 1'b0 : 1'b0,
                     1'b1, 3'b010);
      end

      applyStimulus(1'b1, 4'b0100, 16'hF0F0, 16'hFF00, 1'b1, 3'b001, 9'h000);
      checkOutput("and", 16'hF000, 1'b0, 1'b1, 3'b001);
      applyStimulus(1'b1, 4'b0101, 16'hF0F0, 16'h0F00, 1'b1, 3'b001, 9'h000);
      checkOutput("or", 16'hFFF0, 1'b0, 1'b1, 3'b001);
      applyStimulus(1'b1, 4'b0110, 16'hF0F0, 16'hFF00, 1'b1, 3'b001, 9'h000);
      checkOutput("xor", 16'h0FF0, 1'b0, 1'b1, 3'b001);
      applyStimulus(1'b1, 4'b0111, 16'h00F0, 16'h0000, 1'b1, 3'b011, 9'h000);
      checkOutput("not", 16'hFF0F, 1'b0, 1'b1, 3'b011);

      applyStimulus(1'b0, 4'b0001, 16'hFFFF, 16'hFFFF, 1'b0, 3'b110, 9'h0AA);
      checkOutput("holdA", 16'hFF0F, 1'b0, 1'b1, 3'b011);
      applyStimulus(1'b0, 4'b0010, 16'h0000, 16'h0001, 1'b0, 3'b101, 9'h055);
      checkOutput("holdB", 16'hFF0F, 1'b0, 1'b1, 3'b011);

      applyStimulus(1'b1, 4'b1111, 16'h1234, 16'h0001, 1'b1, 3'b100, 9'h000);
      checkOutput("reserved1111", 16'h0000, 1'b0, 1'b0, 3'b100);
      applyStimulus(1'b1, 4'b1011, 16'h1234, 16'h0001, 1'b1, 3'b101, 9'h000);
      checkOutput("reserved1011", 16'h0000, 1'b0, 1'b0, 3'b101);

`ifdef ALU_SHIFT_EN
      applyStimulus(1'b1, 4'b1000, 16'h0001, 16'h0004, 1'b1, 3'b001, 9'h000);
      checkOutput("shl", 16'h0010, 1'b0, 1'b1, 3'b001);
      applyStimulus(1'b1, 4'b1001, 16'h8000, 16'h0003, 1'b1, 3'b010, 9'h000);
      checkOutput("shr", 16'h1000, 1'b0, 1'b1, 3'b010);
      applyStimulus(1'b1, 4'b1010, 16'h8000, 16'h0013, 1'b1, 3'b011, 9'h000);
      checkOutput("sra", 16'hF000, 1'b0, 1'b1, 3'b011);
`else
      applyStimulus(1'b1, 4'b1000, 16'h0001, 16'h0004, 1'b1, 3'b001, 9'h000);
      checkOutput("shlOff", 16'h0000, 1'b0, 1'b0, 3'b001);
      applyStimulus(1'b1, 4'b1010, 16'h8000, 16'h0003, 1'b1, 3'b011, 9'h000);
      checkOutput("sraOff", 16'h0000, 1'b0, 1'b0, 3'b011);
`endif

      applyStimulus(1'b1, 4'b0001, 16'h7FFF, 16'h8001, 1'b1, 3'b111, 9'h000);
      checkOutput("preReset", 16'h0000, 1'b1, 1'b1, 3'b111);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midRunReset", 16'h0000, 1'b0, 1'b0, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("resetOverridesEnable", 16'h0000, 1'b0, 1'b0, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b1, 4'b0000, 16'hBEEF, 16'h0000, 1'b1, 3'b110, 9'h000);
      checkOutput("passAfterReset", 16'hBEEF, 1'b0, 1'b1, 3'b110);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
